// File: rtl/round_key_store_if.sv
// Bus between the round key store, its host and the key expansion stage.
// The master side (host and expansion stage) drives keys, load, ks_rk and read requests.
// The slave side (the store) drives status, the expansion controls and rk_out.
interface round_key_store_if;
  logic [127:0] key_in;
  logic         load;
  logic         busy;
  logic         ready;
  logic [127:0] ks_key;
  logic [3:0]   ks_ctr;
  logic [127:0] ks_rk;
  logic [3:0]   rd_idx;
  logic         rd_rev;
  logic [127:0] rk_out;

  modport master (
    output key_in, load, ks_rk, rd_idx, rd_rev,
    input  busy, ready, ks_key, ks_ctr, rk_out
  );

  modport slave (
    input  key_in, load, ks_rk, rd_idx, rd_rev,
    output busy, ready, ks_key, ks_ctr, rk_out
  );
endinterface

// File: rtl/round_key_store.sv
// AES-128 round key store.
// It steps the expansion stage's round counter and captures its registered output,
// one round key per cycle, into an 11-entry buffer. Once all keys are in the buffer,
// it serves them by index in forward order or reverse order with 1-cycle latency.
module round_key_store #(
  parameter int NR = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  round_key_store_if.slave bus
);

  localparam int         DEPTH = NR + 1;
  localparam logic [3:0] LAST  = 4'(NR);

  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

  state_t       state, state_next;
  logic         load_acc;
  logic         issue;
  logic         cap_done;
  logic [3:0]   cnt;
  logic         cap_valid;
  logic [3:0]   cap_idx;
  logic [127:0] rk_buf [DEPTH];
  logic [3:0]   rd_sel;
  logic [127:0] rd_word;

  // A counter value is issued to the stage while expanding and cnt has not passed the last round.
  // Capture of the final round key marks completion.
  assign issue    = (state == EXPAND) && (cnt <= LAST);
  assign cap_done = cap_valid && (cap_idx == LAST);

  // State register.
  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic. A load is accepted only when no expansion is running.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_next = state;
    load_acc   = 1'b0;
    case (state)
      IDLE, READY: begin
        if (bus.load) begin
          load_acc   = 1'b1;
          state_next = EXPAND;
        end
      end
      EXPAND:  if (cap_done) state_next = READY;
      default: state_next = IDLE;
    endcase
  end

  // Issue side: latch the key and step ks_ctr 0..10.
  // cap_valid/cap_idx delay the issue by one cycle to line up with the registered ks_rk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      cap_valid  <= 1'b0;
      cap_idx    <= '0;
      bus.ks_key <= '0;
      bus.ks_ctr <= '0;
    end else if (load_acc) begin
      cnt        <= '0;
      cap_valid  <= 1'b0;
      cap_idx    <= '0;
      bus.ks_key <= bus.key_in;
      bus.ks_ctr <= '0;
    end else begin
      cap_valid <= issue;
      cap_idx   <= cnt;
      if (issue) begin
        cnt        <= cnt + 4'd1;
        bus.ks_ctr <= (cnt < LAST) ? cnt + 4'd1 : 4'd0;
      end else begin
        bus.ks_ctr <= '0;
      end
    end
  end

  // Status flags, registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.busy  <= 1'b0;
      bus.ready <= 1'b0;
    end else begin
      bus.busy  <= (state_next == EXPAND);
      bus.ready <= (state_next == READY);
    end
  end

  // Round key buffer, written from the expansion stage one cycle after each issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the buffer is cleared on reset so that no key from before the reset
      // stays in the flops. This rules out a RAM macro here.
      for (int i = 0; i < DEPTH; i++) rk_buf[i] <= '0;
    end else if (cap_valid && (cap_idx <= LAST)) begin
      rk_buf[cap_idx] <= bus.ks_rk;
    end
  end

  // The read mux selects the forward entry or the reversed entry.
  // Out-of-range indices return zero.
  assign rd_sel  = bus.rd_rev ? (LAST - bus.rd_idx) : bus.rd_idx;
  assign rd_word = (bus.rd_idx <= LAST) ? rk_buf[rd_sel] : '0;

  // Registered read port. The output is zero unless all keys are valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.rk_out <= '0;
    else        bus.rk_out <= bus.ready ? rd_word : '0;
  end

endmodule

// File: tb/tb_round_key_store.sv
// Testbench for round_key_store.
// A behavioural AES-128 key expansion serves as the registered expansion stage.
// The same function is the reference model for what the buffer must hold.
// Random keys, reads and stray load pulses are checked against that model,
// and against the published FIPS-197 vectors.
module tb_round_key_store;

  typedef logic [10:0][127:0] keys_t;

  localparam logic [127:0] K_A   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K_A1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K_A10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K_B   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K_B10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [7:0] sbox [256];
  keys_t      model_keys;
  logic       model_ready = 1'b0;
  keys_t      stage_keys;

  round_key_store_if bus ();

  round_key_store #(.NR(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // The S-box is the multiplicative inverse in GF(2^8), followed by the affine map.
  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0]  inv = 8'h00;
      logic [15:0] d;
      for (int x = 1; x < 256; x++)
        if (gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
      d = {inv, inv};
      sbox[a] = inv ^ d[14 -: 8] ^ d[13 -: 8] ^ d[12 -: 8] ^ d[11 -: 8] ^ 8'h63;
    end
  endtask

  function automatic keys_t expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    keys_t       k;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) k[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return k;
  endfunction

  // Expansion stage: round key for the sampled counter, registered.
  always @(posedge clk) begin
    stage_keys = expand(bus.ks_key);
    bus.ks_rk <= (bus.ks_ctr <= 4'd10) ? stage_keys[bus.ks_ctr] : '0;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_read_inputs();
    bus.rd_idx = 4'($urandom_range(15, 0));
    bus.rd_rev = 1'($urandom_range(1, 0));
  endtask

  // A read is expected to return a key only when the model holds a complete set.
  task automatic read_chk(input int idx, input bit rev, input string tag);
    logic [127:0] exp;
    bus.rd_idx = 4'(idx);
    bus.rd_rev = rev;
    tick();
    exp = (model_ready && idx <= 10) ? model_keys[rev ? 10 - idx : idx] : '0;
    check(tag, bus.rk_out, exp);
  endtask

  // Pulse load with key, then follow the full expansion.
  // spur is the edge at which a stray load pulse with a random key is applied (0 = none).
  task automatic do_load(input logic [127:0] key, input int spur);
    bus.key_in = key;
    bus.load   = 1'b1;
    tick();
    bus.load   = 1'b0;
    bus.key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
    model_ready = 1'b0;
    model_keys  = expand(key);
    check("busy_after_load", 128'(bus.busy), 128'd1);
    check("ready_after_load", 128'(bus.ready), 128'd0);
    check("ks_ctr_e0", 128'(bus.ks_ctr), 128'd0);
    check("ks_key_latched", bus.ks_key, key);
    for (int k = 1; k <= 12; k++) begin
      rand_read_inputs();
      if (k == spur) bus.load = 1'b1;
      tick();
      bus.load = 1'b0;
      check($sformatf("ks_ctr_e%0d", k), 128'(bus.ks_ctr), (k <= 10) ? 128'(k) : 128'd0);
      check($sformatf("ready_e%0d", k), 128'(bus.ready), (k == 12) ? 128'd1 : 128'd0);
      check($sformatf("busy_e%0d", k), 128'(bus.busy), (k == 12) ? 128'd0 : 128'd1);
      check($sformatf("rk_out_busy_e%0d", k), bus.rk_out, 128'd0);
    end
    check("ks_key_kept", bus.ks_key, key);
    model_ready = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.key_in = '0;
    bus.load   = 1'b0;
    bus.rd_idx = '0;
    bus.rd_rev = 1'b0;
    bus.ks_rk  = '0;
    build_sbox();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Reset state
    check("rst_busy", 128'(bus.busy), 128'd0);
    check("rst_ready", 128'(bus.ready), 128'd0);
    check("rst_ks_ctr", 128'(bus.ks_ctr), 128'd0);
    check("rst_ks_key", bus.ks_key, 128'd0);
    check("rst_rk_out", bus.rk_out, 128'd0);
    read_chk(0, 1'b0, "idle_read");

    // Sequence and timing for the FIPS key
    do_load(K_A, 0);

    // Forward reads, checked against the published vectors
    read_chk(0, 1'b0, "fwd0");
    check("fwd0_vec", bus.rk_out, K_A);
    read_chk(1, 1'b0, "fwd1");
    check("fwd1_vec", bus.rk_out, K_A1);
    read_chk(10, 1'b0, "fwd10");
    check("fwd10_vec", bus.rk_out, K_A10);

    // Reverse reads and an out-of-range index
    read_chk(0, 1'b1, "rev0");
    check("rev0_vec", bus.rk_out, K_A10);
    read_chk(10, 1'b1, "rev10");
    check("rev10_vec", bus.rk_out, K_A);
    read_chk(12, 1'b1, "rev12");
    read_chk(11, 1'b0, "fwd11");
    read_chk(15, 1'b0, "fwd15");

    // A stray load during expansion is ignored
    do_load(K_A, 5);
    read_chk(0, 1'b0, "spur_fwd0");
    check("spur_fwd0_vec", bus.rk_out, K_A);
    read_chk(1, 1'b0, "spur_fwd1");
    check("spur_fwd1_vec", bus.rk_out, K_A1);
    read_chk(10, 1'b0, "spur_fwd10");
    check("spur_fwd10_vec", bus.rk_out, K_A10);

    // Reset in the middle of an expansion
    bus.key_in = K_B;
    bus.load   = 1'b1;
    tick();
    bus.load = 1'b0;
    model_ready = 1'b0;
    repeat (6) tick();
    check("pre_rst_busy", 128'(bus.busy), 128'd1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 128'(bus.busy), 128'd0);
    check("arst_ready", 128'(bus.ready), 128'd0);
    check("arst_ks_ctr", 128'(bus.ks_ctr), 128'd0);
    check("arst_rk_out", bus.rk_out, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      read_chk(i, 1'(i % 2), "post_rst_read");
      check("post_rst_ready", 128'(bus.ready), 128'd0);
      check("post_rst_ks_ctr", 128'(bus.ks_ctr), 128'd0);
    end

    // Random keys, random stray loads and random reads
    for (int it = 0; it < 6; it++) begin
      do_load({$urandom(), $urandom(), $urandom(), $urandom()}, $urandom_range(12, 0));
      for (int r = 0; r < 10; r++)
        read_chk($urandom_range(15, 0), 1'($urandom_range(1, 0)), "rand_read");
    end

    // Re-expansion from READY with the FIPS-197 appendix key
    do_load(K_B, 0);
    read_chk(10, 1'b0, "b_fwd10");
    check("b_fwd10_vec", bus.rk_out, K_B10);
    read_chk(0, 1'b0, "b_fwd0");
    check("b_fwd0_vec", bus.rk_out, K_B);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
